// File: rtl/stage_execute_pkg.sv
// Shared opcodes, FSM state type and constants for the execute stage.
package stage_execute_pkg;

    // ALU operation select (cmp = 0)
    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_AND   = 4'd2;
    localparam logic [3:0] ALU_OR    = 4'd3;
    localparam logic [3:0] ALU_XOR   = 4'd4;
    localparam logic [3:0] ALU_SHL   = 4'd5;
    localparam logic [3:0] ALU_SHR   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_PASSB = 4'd8;
    localparam logic [3:0] ALU_PASSA = 4'd9;

    // Compare select (cmp = 1)
    localparam logic [3:0] CMP_EQ  = 4'd0;
    localparam logic [3:0] CMP_NE  = 4'd1;
    localparam logic [3:0] CMP_LT  = 4'd2;
    localparam logic [3:0] CMP_LTU = 4'd3;
    localparam logic [3:0] CMP_GE  = 4'd4;
    localparam logic [3:0] CMP_GEU = 4'd5;

    // Shift amount is always taken from the low five bits of operand B
    localparam int unsigned SHAMT_W = 5;

    // Register 0 doubles as the bubble / no-write destination
    localparam int unsigned REG_NULL = 0;

    typedef enum logic {
        StIdle,
        StBusy
    } state_e;

endpackage

// File: rtl/stage_execute_alu.sv
// Purely combinational ALU / comparator for the execute stage.
module stage_execute_alu
    import stage_execute_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [3:0]      aluop_i,
    input  logic            cmp_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic [XLEN-1:0] result_o
);

    logic [SHAMT_W-1:0] shamt;
    logic               flag;

    assign shamt = b_i[SHAMT_W-1:0];

    // Select the arithmetic result or the zero-extended compare flag
    always_comb begin
        result_o = '0;
        flag     = 1'b0;
        if (cmp_i) begin
            case (aluop_i)
                CMP_EQ:  flag = (a_i == b_i);
                CMP_NE:  flag = (a_i != b_i);
                CMP_LT:  flag = ($signed(a_i) < $signed(b_i));
                CMP_LTU: flag = (a_i < b_i);
                CMP_GE:  flag = ($signed(a_i) >= $signed(b_i));
                CMP_GEU: flag = (a_i >= b_i);
                default: flag = 1'b0;
            endcase
            result_o = {{(XLEN-1){1'b0}}, flag};
        end else begin
            case (aluop_i)
                ALU_ADD:   result_o = a_i + b_i;
                ALU_SUB:   result_o = a_i - b_i;
                ALU_AND:   result_o = a_i & b_i;
                ALU_OR:    result_o = a_i | b_i;
                ALU_XOR:   result_o = a_i ^ b_i;
                ALU_SHL:   result_o = a_i << shamt;
                ALU_SHR:   result_o = a_i >> shamt;
                ALU_SRA:   result_o = $signed(a_i) >>> shamt;
                ALU_PASSB: result_o = b_i;
                ALU_PASSA: result_o = a_i;
                default:   result_o = '0;
            endcase
        end
    end

endmodule

// File: rtl/stage_execute.sv
// Execute stage: ALU/compare, load/store bus FSM, forwarding, writeback and jump redirect.
module stage_execute
    import stage_execute_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned RBITS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [XLEN-1:0]  pc_i,
    input  logic [XLEN-1:0]  reg_a_i,
    input  logic [XLEN-1:0]  reg_b_i,
    input  logic [XLEN-1:0]  reg_m_i,
    input  logic [RBITS-1:0] dest_i,
    input  logic [3:0]       aluop_i,
    input  logic             cmp_i,
    input  logic             mem_i,
    input  logic             mem_write_i,
    input  logic             jump_i,
    output logic             stall_o,
    output logic             forward_valid_o,
    output logic [RBITS-1:0] forward_addr_o,
    output logic [XLEN-1:0]  forward_data_o,
    output logic [RBITS-1:0] write_addr_o,
    output logic [XLEN-1:0]  write_data_o,
    output logic             redirect_o,
    output logic [XLEN-1:0]  redirect_pc_o,
    output logic             bus_req_o,
    output logic             bus_we_o,
    output logic [XLEN-1:0]  bus_addr_o,
    output logic [XLEN-1:0]  bus_wdata_o,
    input  logic             bus_ready_i,
    input  logic [XLEN-1:0]  bus_rdata_i
);

    localparam logic [RBITS-1:0] RegNull = RBITS'(REG_NULL);

    state_e           state_q, state_d;
    logic [RBITS-1:0] write_addr_q, write_addr_d;
    logic [XLEN-1:0]  write_data_q, write_data_d;
    logic             redirect_q, redirect_d;
    logic [XLEN-1:0]  redirect_pc_q, redirect_pc_d;
    logic             bus_req_q, bus_req_d;
    logic             bus_we_q, bus_we_d;
    logic [XLEN-1:0]  bus_addr_q, bus_addr_d;
    logic [XLEN-1:0]  bus_wdata_q, bus_wdata_d;

    logic [XLEN-1:0]  alu_result;
    logic [XLEN-1:0]  mem_addr;
    logic             has_dest;
    logic             start_mem;

    // The jump target comes from the ALU result, so pc is informational only
    logic unused_pc;
    assign unused_pc = ^pc_i;

    stage_execute_alu #(
        .XLEN (XLEN)
    ) u_alu (
        .aluop_i  (aluop_i),
        .cmp_i    (cmp_i),
        .a_i      (reg_a_i),
        .b_i      (reg_b_i),
        .result_o (alu_result)
    );

    assign mem_addr  = reg_a_i + reg_b_i;
    assign has_dest  = (dest_i != RegNull);
    // A load into r0 is a bubble; stores always go to the bus
    assign start_mem = mem_i && (has_dest || mem_write_i);

    // Next-state, registered-output updates and combinational stall/forward
    always_comb begin
        state_d         = state_q;
        write_addr_d    = RegNull;
        write_data_d    = write_data_q;
        redirect_d      = 1'b0;
        redirect_pc_d   = redirect_pc_q;
        bus_req_d       = bus_req_q;
        bus_we_d        = bus_we_q;
        bus_addr_d      = bus_addr_q;
        bus_wdata_d     = bus_wdata_q;
        stall_o         = 1'b0;
        forward_valid_o = 1'b1;
        forward_addr_o  = dest_i;
        forward_data_o  = alu_result;

        case (state_q)
            StIdle: begin
                if (start_mem) begin
                    stall_o         = 1'b1;
                    // Stores produce nothing to forward; loads are not final yet
                    forward_valid_o = mem_write_i;
                    forward_addr_o  = mem_write_i ? RegNull : dest_i;
                    bus_req_d       = 1'b1;
                    bus_we_d        = mem_write_i;
                    bus_addr_d      = mem_addr;
                    bus_wdata_d     = reg_m_i;
                    state_d         = StBusy;
                end else if (!mem_i) begin
                    if (has_dest) begin
                        write_addr_d = dest_i;
                        write_data_d = alu_result;
                    end
                    if (jump_i) begin
                        redirect_d    = 1'b1;
                        redirect_pc_d = alu_result;
                    end
                end
            end
            StBusy: begin
                stall_o = ~bus_ready_i;
                if (bus_we_q) begin
                    forward_addr_o  = RegNull;
                end else begin
                    forward_valid_o = bus_ready_i;
                    forward_data_o  = bus_rdata_i;
                end
                if (bus_ready_i) begin
                    bus_req_d = 1'b0;
                    state_d   = StIdle;
                    if (!bus_we_q) begin
                        write_addr_d = dest_i;
                        write_data_d = bus_rdata_i;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers; reset abandons any bus transaction in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            write_addr_q  <= RegNull;
            write_data_q  <= '0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            bus_req_q     <= 1'b0;
            bus_we_q      <= 1'b0;
            bus_addr_q    <= '0;
            bus_wdata_q   <= '0;
        end else begin
            state_q       <= state_d;
            write_addr_q  <= write_addr_d;
            write_data_q  <= write_data_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
            bus_req_q     <= bus_req_d;
            bus_we_q      <= bus_we_d;
            bus_addr_q    <= bus_addr_d;
            bus_wdata_q   <= bus_wdata_d;
        end
    end

    assign write_addr_o  = write_addr_q;
    assign write_data_o  = write_data_q;
    assign redirect_o    = redirect_q;
    assign redirect_pc_o = redirect_pc_q;
    assign bus_req_o     = bus_req_q;
    assign bus_we_o      = bus_we_q;
    assign bus_addr_o    = bus_addr_q;
    assign bus_wdata_o   = bus_wdata_q;

endmodule

// File: tb/tb_stage_execute.sv
// Scoreboard bench for stage_execute: writebacks are queued at issue and matched on write_addr.
module tb_stage_execute;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_i, reg_a_i, reg_b_i, reg_m_i;
    logic [3:0]  dest_i, aluop_i;
    logic        cmp_i, mem_i, mem_write_i, jump_i;
    logic        stall_o, forward_valid_o;
    logic [3:0]  forward_addr_o, write_addr_o;
    logic [31:0] forward_data_o, write_data_o;
    logic        redirect_o;
    logic [31:0] redirect_pc_o;
    logic        bus_req_o, bus_we_o;
    logic [31:0] bus_addr_o, bus_wdata_o;
    logic        bus_ready_i;
    logic [31:0] bus_rdata_i;

    typedef struct packed {
        logic [3:0]  addr;
        logic [31:0] data;
    } wb_t;

    wb_t sb_q[$];
    int  n_checks = 0;
    int  n_pass   = 0;

    stage_execute #(
        .XLEN  (32),
        .RBITS (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .pc_i            (pc_i),
        .reg_a_i         (reg_a_i),
        .reg_b_i         (reg_b_i),
        .reg_m_i         (reg_m_i),
        .dest_i          (dest_i),
        .aluop_i         (aluop_i),
        .cmp_i           (cmp_i),
        .mem_i           (mem_i),
        .mem_write_i     (mem_write_i),
        .jump_i          (jump_i),
        .stall_o         (stall_o),
        .forward_valid_o (forward_valid_o),
        .forward_addr_o  (forward_addr_o),
        .forward_data_o  (forward_data_o),
        .write_addr_o    (write_addr_o),
        .write_data_o    (write_data_o),
        .redirect_o      (redirect_o),
        .redirect_pc_o   (redirect_pc_o),
        .bus_req_o       (bus_req_o),
        .bus_we_o        (bus_we_o),
        .bus_addr_o      (bus_addr_o),
        .bus_wdata_o     (bus_wdata_o),
        .bus_ready_i     (bus_ready_i),
        .bus_rdata_i     (bus_rdata_i)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Any register-file write must match the oldest queued expectation
    always @(negedge clk) begin
        if (!rst && write_addr_o != 4'd0) begin
            if (sb_q.size() == 0) begin
                check_eq("wb_unexpected", 32'(write_addr_o), 32'd0);
            end else begin
                wb_t e;
                e = sb_q.pop_front();
                check_eq("wb_addr", 32'(write_addr_o), 32'(e.addr));
                check_eq("wb_data", write_data_o, e.data);
            end
        end
    end

    task automatic drive_bubble();
        pc_i = 32'd0; reg_a_i = 32'd0; reg_b_i = 32'd0; reg_m_i = 32'd0;
        dest_i = 4'd0; aluop_i = 4'd0; cmp_i = 1'b0;
        mem_i = 1'b0; mem_write_i = 1'b0; jump_i = 1'b0;
    endtask

    // Called just after a rising edge; returns just after the next rising edge
    task automatic run_alu(input string tag, input logic [3:0] op, input logic cmp,
                           input logic [31:0] a, input logic [31:0] b, input logic [3:0] dest,
                           input logic jump, input logic [31:0] exp);
        pc_i = 32'h10; reg_a_i = a; reg_b_i = b; reg_m_i = 32'd0;
        dest_i = dest; aluop_i = op; cmp_i = cmp;
        mem_i = 1'b0; mem_write_i = 1'b0; jump_i = jump;
        @(negedge clk);
        check_eq({tag, "_fdata"}, forward_data_o, exp);
        check_eq({tag, "_fv_stall"}, {30'd0, forward_valid_o, stall_o}, 32'd2);
        check_eq({tag, "_faddr"}, 32'(forward_addr_o), 32'(dest));
        if (dest != 4'd0) sb_q.push_back('{addr: dest, data: exp});
        @(posedge clk); #1;
    endtask

    // Memory op with a bus that answers after `waits` request cycles
    task automatic do_mem(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] m, input logic we, input logic [3:0] dest,
                          input int waits, input logic [31:0] rdata,
                          input logic [31:0] exp_addr, input int exp_stall);
        int  stall_cnt = 0;
        int  req_wait  = 0;
        int  fv_early  = 0;
        bit  done      = 0;
        reg_a_i = a; reg_b_i = b; reg_m_i = m; dest_i = dest;
        aluop_i = 4'd0; cmp_i = 1'b0; mem_i = 1'b1; mem_write_i = we; jump_i = 1'b0;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            @(negedge clk);
            if (bus_req_o) begin
                if (req_wait == waits) begin
                    bus_ready_i = 1'b1;
                    bus_rdata_i = rdata;
                end else begin
                    req_wait++;
                end
            end
            #1;
            if (stall_o) stall_cnt++;
            if (!bus_ready_i && !we && forward_valid_o) fv_early++;
            if (bus_ready_i) begin
                check_eq({tag, "_addr"}, bus_addr_o, exp_addr);
                check_eq({tag, "_we"}, 32'(bus_we_o), 32'(we));
                if (we) begin
                    check_eq({tag, "_wdata"}, bus_wdata_o, m);
                end else begin
                    check_eq({tag, "_fv"}, 32'(forward_valid_o), 32'd1);
                    check_eq({tag, "_fdata"}, forward_data_o, rdata);
                    sb_q.push_back('{addr: dest, data: rdata});
                end
                done = 1;
            end
        end
        check_eq({tag, "_done"}, 32'(done), 32'd1);
        check_eq({tag, "_stall_cycles"}, 32'(stall_cnt), 32'(exp_stall));
        check_eq({tag, "_req_waits"}, 32'(req_wait), 32'(waits));
        if (!we) check_eq({tag, "_fv_early"}, 32'(fv_early), 32'd0);
        @(posedge clk); #1;
        bus_ready_i = 1'b0;
        drive_bubble();
        check_eq({tag, "_req_drop"}, 32'(bus_req_o), 32'd0);
        if (we) check_eq({tag, "_no_write"}, 32'(write_addr_o), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        bus_ready_i = 1'b0;
        bus_rdata_i = 32'd0;
        drive_bubble();
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_ctrl", {28'd0, bus_req_o, bus_we_o, redirect_o, stall_o}, 32'd0);
        check_eq("rst_waddr", 32'(write_addr_o), 32'd0);
        check_eq("rst_wdata", write_data_o, 32'd0);
        check_eq("rst_rpc", redirect_pc_o, 32'd0);
        check_eq("rst_baddr", bus_addr_o, 32'd0);
        check_eq("rst_bwdata", bus_wdata_o, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // ALU and compare, back to back
        run_alu("add",   4'd0,  1'b0, 32'd5,        32'hFFFFFFFE, 4'd3,  1'b0, 32'd3);
        check_eq("add_no_redirect", 32'(redirect_o), 32'd0);
        run_alu("sub",   4'd1,  1'b0, 32'd3,        32'd5,        4'd1,  1'b0, 32'hFFFFFFFE);
        run_alu("and",   4'd2,  1'b0, 32'hF0F0,     32'hFF00,     4'd2,  1'b0, 32'hF000);
        run_alu("or",    4'd3,  1'b0, 32'hF0F0,     32'h0F00,     4'd4,  1'b0, 32'hFFF0);
        run_alu("xor",   4'd4,  1'b0, 32'hFF,       32'h0F,       4'd6,  1'b0, 32'hF0);
        run_alu("shl",   4'd5,  1'b0, 32'd1,        32'h21,       4'd7,  1'b0, 32'd2);
        run_alu("shr",   4'd6,  1'b0, 32'h80000000, 32'd4,        4'd8,  1'b0, 32'h08000000);
        run_alu("sra",   4'd7,  1'b0, 32'h80000000, 32'd4,        4'd9,  1'b0, 32'hF8000000);
        run_alu("passb", 4'd8,  1'b0, 32'd7,        32'h1234,     4'd10, 1'b0, 32'h1234);
        run_alu("passa", 4'd9,  1'b0, 32'hABCD,     32'd7,        4'd11, 1'b0, 32'hABCD);
        run_alu("badop", 4'd10, 1'b0, 32'd5,        32'd6,        4'd12, 1'b0, 32'd0);
        run_alu("ltu",   4'd3,  1'b1, 32'd1,        32'hFFFFFFFF, 4'd13, 1'b0, 32'd1);
        run_alu("lt",    4'd2,  1'b1, 32'd1,        32'hFFFFFFFF, 4'd14, 1'b0, 32'd0);
        run_alu("eq",    4'd0,  1'b1, 32'd7,        32'd7,        4'd1,  1'b0, 32'd1);
        run_alu("ne",    4'd1,  1'b1, 32'd7,        32'd7,        4'd2,  1'b0, 32'd0);
        run_alu("ge",    4'd4,  1'b1, 32'hFFFFFFFF, 32'd1,        4'd3,  1'b0, 32'd0);
        run_alu("geu",   4'd5,  1'b1, 32'hFFFFFFFF, 32'd1,        4'd4,  1'b0, 32'd1);
        run_alu("badcmp", 4'd6, 1'b1, 32'd1,        32'd2,        4'd5,  1'b0, 32'd0);
        run_alu("bubble", 4'd0, 1'b0, 32'd1,        32'd2,        4'd0,  1'b0, 32'd3);

        // Jump with link: one-cycle redirect to the pass-A result
        run_alu("jump",  4'd9,  1'b0, 32'h40,       32'd0,        4'd15, 1'b1, 32'h40);
        drive_bubble();
        @(negedge clk);
        check_eq("jump_redirect", 32'(redirect_o), 32'd1);
        check_eq("jump_pc", redirect_pc_o, 32'h40);
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("jump_pulse_end", 32'(redirect_o), 32'd0);
        @(posedge clk); #1;

        // Load with three wait cycles, then an immediate store
        do_mem("load", 32'h100, 32'd4, 32'd0, 1'b0, 4'd5, 3, 32'hDEADBEEF, 32'h104, 4);
        do_mem("store", 32'h200, 32'd0, 32'h55, 1'b1, 4'd0, 0, 32'd0, 32'h200, 1);
        @(negedge clk);
        check_eq("store_no_write_late", 32'(write_addr_o), 32'd0);
        @(posedge clk); #1;

        // Reset in the middle of a load that the bus never answers
        reg_a_i = 32'h300; reg_b_i = 32'd0; dest_i = 4'd6; mem_i = 1'b1; mem_write_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("busy_req", {30'd0, bus_req_o, stall_o}, 32'd3);
        #2;
        rst = 1'b1;
        drive_bubble();
        #1;
        check_eq("midrst_outs", {28'd0, bus_req_o, stall_o, redirect_o, bus_we_o}, 32'd0);
        check_eq("midrst_waddr", 32'(write_addr_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        run_alu("post_rst", 4'd0, 1'b0, 32'd10, 32'd20, 4'd7, 1'b0, 32'd30);
        drive_bubble();
        repeat (3) @(posedge clk);
        #1;
        check_eq("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
